pwm_ctrl: RTL and testbench

Command-driven controller for a bank of `pwm` channels. It sits between the SPI command decoder and the `pwm` instances, and owns each channel's enable and duty value. It accepts per-channel commands over a valid/ready handshake. It optionally fades each channel's duty toward its target by a fixed step once per PWM period, sequencing the update across channels with a small state machine.

---
 rtl/pwm_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: command-driven enable/duty owner for a bank of pwm channels.
// Define PWM_CTRL_FADE_EN to fade each duty toward its target once per tick.
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif

module pwm_ctrl #(
    parameter int CH_W = 2,
    parameter int BW   = `BRIGHTNESS_WIDTH,
    parameter int STEP = 1
) (
    input  logic                    sysclk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [1:0]              i_cmd_op,
    input  logic [CH_W-1:0]         i_cmd_ch,
    input  logic [BW-1:0]           i_cmd_data,
    input  logic                    i_tick,
    output logic [(2**CH_W)-1:0]    o_enb,
    output logic [(2**CH_W)*BW-1:0] o_d,
    output logic                    o_busy
);
    localparam int N_CH = 2**CH_W;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_ENA  = 2'b01;
    localparam logic [1:0] OP_DIS  = 2'b10;
    localparam logic [1:0] OP_DALL = 2'b11;

`ifdef PWM_CTRL_FADE_EN
    typedef enum logic [1:0] {IDLE, EXEC, FADE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

    state_t            state;
    logic [1:0]        op_q;
    logic [CH_W-1:0]   ch_q;
    logic [BW-1:0]     data_q;
    logic [BW-1:0]     cur   [N_CH];
    logic [BW-1:0]     tgt   [N_CH];
    logic [BW-1:0]     cur_n [N_CH];
    logic [BW-1:0]     tgt_n [N_CH];
    logic [N_CH-1:0]   enb_n;

`ifdef PWM_CTRL_FADE_EN
    localparam logic [BW:0] STEP_V = (BW+1)'(STEP);

    logic            pend;
    logic [CH_W-1:0] idx;
    logic            busy_n;

    // Widened by one bit so the step clamp cannot wrap past the target.
    function automatic logic [BW-1:0] fade(
        input logic [BW-1:0] c,
        input logic [BW-1:0] t
    );
        logic [BW:0] d;
        logic [BW:0] r;
        r = {1'b0, c};
        if (c < t) begin
            d = {1'b0, t} - {1'b0, c};
            if (d > STEP_V) d = STEP_V;
            r = {1'b0, c} + d;
        end else if (c > t) begin
            d = {1'b0, c} - {1'b0, t};
            if (d > STEP_V) d = STEP_V;
            r = {1'b0, c} - d;
        end
        return r[BW-1:0];
    endfunction
`else
    localparam int step_unused = STEP;
    logic tick_unused;
    assign tick_unused = i_tick;
`endif

    always_comb begin
        cur_n = cur;
        tgt_n = tgt;
        enb_n = o_enb;
        if (state == EXEC) begin
            unique case (op_q)
                OP_SET: begin
                    tgt_n[ch_q] = data_q;
`ifndef PWM_CTRL_FADE_EN
                    cur_n[ch_q] = data_q;
`endif
                end
                OP_ENA: enb_n[ch_q] = 1'b1;
                OP_DIS: begin
                    enb_n[ch_q] = 1'b0;
                    cur_n[ch_q] = '0;
                end
                OP_DALL: begin
                    enb_n = '0;
                    for (int k = 0; k < N_CH; k++) cur_n[k] = '0;
                end
            endcase
        end
`ifdef PWM_CTRL_FADE_EN
        else if (state == FADE) begin
            cur_n[idx] = fade(cur[idx], tgt[idx]);
        end
        busy_n = 1'b0;
        for (int k = 0; k < N_CH; k++)
            busy_n = busy_n | (cur_n[k] != tgt_n[k]);
`endif
    end

    always_comb begin
        o_d = '0;
        for (int k = 0; k < N_CH; k++) o_d[k*BW +: BW] = cur[k];
    end

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b0;
            o_enb       <= '0;
            op_q        <= OP_SET;
            ch_q        <= '0;
            data_q      <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cur[k] <= '0;
                tgt[k] <= '0;
            end
`ifdef PWM_CTRL_FADE_EN
            o_busy <= 1'b0;
            pend   <= 1'b0;
            idx    <= '0;
`endif
        end else begin
            cur   <= cur_n;
            tgt   <= tgt_n;
            o_enb <= enb_n;
`ifdef PWM_CTRL_FADE_EN
            o_busy <= busy_n;
`endif
            unique case (state)
                IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        op_q        <= i_cmd_op;
                        ch_q        <= i_cmd_ch;
                        data_q      <= i_cmd_data;
                        state       <= EXEC;
                        o_cmd_ready <= 1'b0;
                    end
`ifdef PWM_CTRL_FADE_EN
                    else if (pend) begin
                        state       <= FADE;
                        idx         <= '0;
                        pend        <= 1'b0;
                        o_cmd_ready <= 1'b0;
                    end
`endif
                    else begin
                        o_cmd_ready <= 1'b1;
                    end
                end
                EXEC: begin
`ifdef PWM_CTRL_FADE_EN
                    if (pend) begin
                        state <= FADE;
                        idx   <= '0;
                        pend  <= 1'b0;
                    end else
`endif
                    begin
                        state       <= IDLE;
                        o_cmd_ready <= 1'b1;
                    end
                end
`ifdef PWM_CTRL_FADE_EN
                FADE: begin
                    if (idx == CH_W'(N_CH-1)) begin
                        if (pend) begin
                            idx  <= '0;
                            pend <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            o_cmd_ready <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef PWM_CTRL_FADE_EN
            // A tick on the clearing edge still leaves a sweep owed.
            if (i_tick) pend <= 1'b1;
`endif
        end
    end

`ifndef PWM_CTRL_FADE_EN
    assign o_busy = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed self-checking bench for pwm_ctrl.
// Fade vectors are used when PWM_CTRL_FADE_EN is defined.
`timescale 1ns/1ps

module tb_pwm_ctrl;
    localparam int CH_W = 2;
    localparam int BW   = 8;
    localparam int N_CH = 4;

    localparam logic [1:0] SET  = 2'b00;
    localparam logic [1:0] ENA  = 2'b01;
    localparam logic [1:0] DIS  = 2'b10;
    localparam logic [1:0] DALL = 2'b11;

    logic            sysclk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_cmd_valid = 1'b0;
    logic            i_tick = 1'b0;
    logic [1:0]      i_cmd_op = 2'b00;
    logic [CH_W-1:0] i_cmd_ch = '0;
    logic [BW-1:0]   i_cmd_data = '0;

    logic        rdy_a;
    logic [3:0]  enb_a;
    logic [31:0] d_a;
    logic        busy_a;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    pwm_ctrl #(.CH_W(CH_W), .BW(BW), .STEP(16)) u_a (
        .sysclk     (sysclk),
        .i_rst      (i_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(rdy_a),
        .i_cmd_op   (i_cmd_op),
        .i_cmd_ch   (i_cmd_ch),
        .i_cmd_data (i_cmd_data),
        .i_tick     (i_tick),
        .o_enb      (enb_a),
        .o_d        (d_a),
        .o_busy     (busy_a)
    );

`ifdef PWM_CTRL_FADE_EN
    logic        rdy_b;
    logic [3:0]  enb_b;
    logic [31:0] d_b;
    logic        busy_b;

    pwm_ctrl #(.CH_W(CH_W), .BW(BW), .STEP(48)) u_b (
        .sysclk     (sysclk),
        .i_rst      (i_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(rdy_b),
        .i_cmd_op   (i_cmd_op),
        .i_cmd_ch   (i_cmd_ch),
        .i_cmd_data (i_cmd_data),
        .i_tick     (i_tick),
        .o_enb      (enb_b),
        .o_d        (d_b),
        .o_busy     (busy_b)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!rdy_a && n < 32) begin
            step();
            n++;
        end
        check("wait_ready", {31'd0, rdy_a}, 32'd1);
    endtask

    // Returns one edge after the handshake edge, i.e. after EXEC.
    task automatic cmd(input logic [1:0] op, input int ch,
                       input logic [7:0] data);
        wait_ready();
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_ch    = CH_W'(ch);
        i_cmd_data  = data;
        step();
        i_cmd_valid = 1'b0;
        check("ready_drop", {31'd0, rdy_a}, 32'd0);
        step();
    endtask

`ifdef PWM_CTRL_FADE_EN
    task automatic sweep();
        int n;
        n = 0;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        while (rdy_a && n < 8) begin
            step();
            n++;
        end
        n = 0;
        while (!rdy_a && n < 20) begin
            step();
            n++;
        end
        check("sweep_len", n, N_CH);
    endtask
`endif

    initial begin
        i_rst = 1'b1;
        step();
        step();
        check("rst_enb", {28'd0, enb_a}, 32'd0);
        check("rst_d", d_a, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_rdy", {31'd0, rdy_a}, 32'd0);
        i_rst = 1'b0;
        step();
        check("rdy_release", {31'd0, rdy_a}, 32'd1);

`ifndef PWM_CTRL_FADE_EN
        cmd(SET, 2, 8'hC8);
        check("set2_d", d_a, 32'h00C8_0000);
        check("set2_rdy", {31'd0, rdy_a}, 32'd1);
        cmd(ENA, 2, 8'h00);
        check("ena2", {28'd0, enb_a}, 32'h4);
        cmd(SET, 0, 8'h55);
        check("set0_d", d_a, 32'h00C8_0055);

        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        step();
        step();
        check("tick_rdy", {31'd0, rdy_a}, 32'd1);
        check("tick_busy", {31'd0, busy_a}, 32'd0);
        check("tick_d", d_a, 32'h00C8_0055);

        cmd(DIS, 2, 8'h00);
        check("dis2_enb", {28'd0, enb_a}, 32'h0);
        check("dis2_d", d_a, 32'h0000_0055);
        cmd(ENA, 0, 8'h00);
        cmd(ENA, 3, 8'h00);
        check("ena03", {28'd0, enb_a}, 32'h9);
        cmd(DALL, 1, 8'h00);
        check("dall_enb", {28'd0, enb_a}, 32'h0);
        check("dall_d", d_a, 32'h0);
        cmd(SET, 3, 8'hFF);
        check("set3_ff", d_a, 32'hFF00_0000);
        cmd(SET, 3, 8'h01);
        check("set3_01", d_a, 32'h0100_0000);

        cmd(ENA, 1, 8'h00);
        wait_ready();
        i_cmd_valid = 1'b1;
        i_cmd_op    = SET;
        i_cmd_ch    = 2'd1;
        i_cmd_data  = 8'h77;
        step();
        i_cmd_valid = 1'b0;
        i_rst = 1'b1;
        step();
        check("rstx_d", d_a, 32'h0);
        check("rstx_enb", {28'd0, enb_a}, 32'h0);
        check("rstx_rdy", {31'd0, rdy_a}, 32'd0);
        i_rst = 1'b0;
        step();
        step();
        check("rstx_after_d", d_a, 32'h0);
        check("rstx_after_rdy", {31'd0, rdy_a}, 32'd1);
`else
        cmd(SET, 0, 8'h40);
        check("fset_d", d_a, 32'h0);
        check("fset_busy", {31'd0, busy_a}, 32'd1);
        check("fset_rdy", {31'd0, rdy_a}, 32'd1);
        sweep();
        check("up1_a", d_a, 32'h10);
        check("up1_b", d_b, 32'h30);
        check("up1_busy_b", {31'd0, busy_b}, 32'd1);
        sweep();
        check("up2_a", d_a, 32'h20);
        check("up2_b", d_b, 32'h40);
        check("up2_busy_b", {31'd0, busy_b}, 32'd0);
        sweep();
        check("up3_a", d_a, 32'h30);
        check("up3_busy_a", {31'd0, busy_a}, 32'd1);
        sweep();
        check("up4_a", d_a, 32'h40);
        check("up4_busy_a", {31'd0, busy_a}, 32'd0);
        check("up4_b", d_b, 32'h40);

        begin
            int n;
            wait_ready();
            i_cmd_valid = 1'b1;
            i_cmd_op    = SET;
            i_cmd_ch    = 2'd0;
            i_cmd_data  = 8'h10;
            i_tick      = 1'b1;
            step();
            i_cmd_valid = 1'b0;
            i_tick      = 1'b0;
            n = 0;
            while (!rdy_a && n < 20) begin
                step();
                n++;
            end
            check("coll_len", n, 1 + N_CH);
            check("coll_a", d_a, 32'h30);
            check("coll_b", d_b, 32'h10);
        end

        cmd(SET, 1, 8'h20);
        cmd(ENA, 1, 8'h00);
        check("ena1", {28'd0, enb_a}, 32'h2);
        sweep();
        check("mix_a", d_a, 32'h0000_1020);
        check("mix_b", d_b, 32'h0000_2010);
        cmd(DALL, 0, 8'h00);
        check("dall_enb", {28'd0, enb_a}, 32'h0);
        check("dall_a", d_a, 32'h0);
        check("dall_b", d_b, 32'h0);
        check("dall_busy", {31'd0, busy_a}, 32'd1);
        cmd(ENA, 1, 8'h00);
        check("reena1", {28'd0, enb_a}, 32'h2);
        sweep();
        check("ramp1_a", d_a, 32'h0000_1010);
        check("ramp1_b", d_b, 32'h0000_2010);
        check("ramp1_busy_a", {31'd0, busy_a}, 32'd1);
        check("ramp1_busy_b", {31'd0, busy_b}, 32'd0);
        sweep();
        check("ramp2_a", d_a, 32'h0000_2010);
        check("ramp2_busy_a", {31'd0, busy_a}, 32'd0);

        cmd(SET, 2, 8'h80);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        step();
        check("mid_rdy", {31'd0, rdy_a}, 32'd0);
        step();
        i_rst = 1'b1;
        step();
        check("midrst_d_a", d_a, 32'h0);
        check("midrst_d_b", d_b, 32'h0);
        check("midrst_enb", {28'd0, enb_a}, 32'h0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_rdy", {31'd0, rdy_a}, 32'd0);
        i_rst = 1'b0;
        step();
        step();
        step();
        check("post_d", d_a, 32'h0);
        check("post_rdy", {31'd0, rdy_a}, 32'd1);
        check("post_busy", {31'd0, busy_a}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
